// File: rtl/itcm_ctrl.sv
// itcm_ctrl
//   Instruction-TCM controller between the IFU fetch-request channel and a
//   single-port synchronous SRAM with one-cycle read latency.
//   - Accepts one fetch command per cycle (valid/ready).
//   - Returns the instruction word one cycle after the command handshake.
//   - Tracks whether the SRAM output register still holds the last word read
//     (holdup). A fetch to that same word skips the SRAM access.
//   - A misaligned fetch (addr[1:0] != 0) gets an error response with zero data.
//
// Ports
//   clk, rst_n             core clock, async active-low reset
//   ifu2itcm_cmd_*         fetch command: valid/ready/byte address
//   ifu2itcm_rsp_*         fetch response: valid/ready/rdata/err
//   ifu2itcm_holdup        SRAM output currently holds the word at last_addr
//   itcm_ram_cs/addr/dout  SRAM read enable, word address, read data
module itcm_ctrl #(
  parameter int ITCM_ADDR_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ifu2itcm_cmd_valid,
  output logic                       ifu2itcm_cmd_ready,
  input  logic [ITCM_ADDR_WIDTH-1:0] ifu2itcm_cmd_addr,
  output logic                       ifu2itcm_rsp_valid,
  input  logic                       ifu2itcm_rsp_ready,
  output logic [31:0]                ifu2itcm_rsp_rdata,
  output logic                       ifu2itcm_rsp_err,
  output logic                       ifu2itcm_holdup,
  output logic                       itcm_ram_cs,
  output logic [ITCM_ADDR_WIDTH-3:0] itcm_ram_addr,
  input  logic [31:0]                itcm_ram_dout
);

  localparam int WAW = ITCM_ADDR_WIDTH - 2;

  logic           rsp_vld_q,   rsp_vld_d;
  logic           rsp_err_q,   rsp_err_d;
  logic           holdup_q,    holdup_d;
  logic [WAW-1:0] last_addr_q, last_addr_d;

  logic           cmd_ready;
  logic           cmd_hsk;
  logic           rsp_hsk;
  logic           misalgn;
  logic           reuse;
  logic           ram_cs;
  logic [WAW-1:0] word_addr;

  always_comb begin
    word_addr = ifu2itcm_cmd_addr[ITCM_ADDR_WIDTH-1:2];
    // A pending response blocks new commands unless it is drained this cycle,
    // so the SRAM output cannot change under a stalled response.
    cmd_ready = ~rsp_vld_q | ifu2itcm_rsp_ready;
    cmd_hsk   = ifu2itcm_cmd_valid & cmd_ready;
    rsp_hsk   = rsp_vld_q & ifu2itcm_rsp_ready;
    misalgn   = ifu2itcm_cmd_addr[1:0] != 2'b00;
    // The SRAM output register already has this word; no read needed.
    reuse     = holdup_q & (word_addr == last_addr_q);
    ram_cs    = cmd_hsk & ~misalgn & ~reuse;
  end

  always_comb begin
    rsp_vld_d   = rsp_vld_q;
    rsp_err_d   = rsp_err_q;
    holdup_d    = holdup_q;
    last_addr_d = last_addr_q;
    if (cmd_hsk) begin
      // New command overrides a response drained in the same cycle.
      rsp_vld_d = 1'b1;
      rsp_err_d = misalgn;
      if (ram_cs) begin
        last_addr_d = word_addr;
        holdup_d    = 1'b1;
      end
    end else if (rsp_hsk) begin
      rsp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      holdup_q    <= 1'b0;
      last_addr_q <= '0;
    end else begin
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      holdup_q    <= holdup_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign ifu2itcm_cmd_ready = cmd_ready;
  assign ifu2itcm_rsp_valid = rsp_vld_q;
  assign ifu2itcm_rsp_err   = rsp_err_q;
  assign ifu2itcm_rsp_rdata = rsp_err_q ? 32'h0 : itcm_ram_dout;
  assign ifu2itcm_holdup    = holdup_q;
  assign itcm_ram_cs        = ram_cs;
  assign itcm_ram_addr      = word_addr;

endmodule

// File: tb/tb_itcm_ctrl.sv
// Directed bench for itcm_ctrl with a behavioural one-cycle-latency SRAM.
// SRAM word i holds 32'hCAFE0000 | i.
module tb_itcm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        holdup;
  logic        ram_cs;
  logic [13:0] ram_addr;
  logic [31:0] ram_dout = 32'h0;

  logic [31:0] mem [0:16383];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  itcm_ctrl #(.ITCM_ADDR_WIDTH(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ifu2itcm_cmd_valid (cmd_valid),
    .ifu2itcm_cmd_ready (cmd_ready),
    .ifu2itcm_cmd_addr  (cmd_addr),
    .ifu2itcm_rsp_valid (rsp_valid),
    .ifu2itcm_rsp_ready (rsp_ready),
    .ifu2itcm_rsp_rdata (rsp_rdata),
    .ifu2itcm_rsp_err   (rsp_err),
    .ifu2itcm_holdup    (holdup),
    .itcm_ram_cs        (ram_cs),
    .itcm_ram_addr      (ram_addr),
    .itcm_ram_dout      (ram_dout)
  );

  // SRAM: read data appears the cycle after cs and holds until the next cs.
  always @(posedge clk) if (ram_cs) ram_dout <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hCAFE0000 | i;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 16'h0; rsp_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_holdup",    32'(holdup),    32'd0);
    chk("rst_cs",        32'(ram_cs),    32'd0);
    rst_n = 1'b1;
    step();

    // Single fetch 0x0010
    cmd_valid = 1'b1; cmd_addr = 16'h0010; #1;
    chk("f10_cs",   32'(ram_cs),   32'd1);
    chk("f10_addr", 32'(ram_addr), 32'h4);
    step(); cmd_valid = 1'b0; #1;
    chk("f10_vld",    32'(rsp_valid), 32'd1);
    chk("f10_rdata",  rsp_rdata,      32'hCAFE0004);
    chk("f10_err",    32'(rsp_err),   32'd0);
    chk("f10_holdup", 32'(holdup),    32'd1);

    // Back-to-back 0x0, 0x4, 0x8 (first one overlaps the drain of 0x10)
    cmd_valid = 1'b1; cmd_addr = 16'h0000; #1;
    chk("b2b0_rdy", 32'(cmd_ready), 32'd1);
    chk("b2b0_cs",  32'(ram_cs),    32'd1);
    step(); cmd_addr = 16'h0004; #1;
    chk("b2b1_rdy",   32'(cmd_ready), 32'd1);
    chk("b2b0_vld",   32'(rsp_valid), 32'd1);
    chk("b2b0_rdata", rsp_rdata,      32'hCAFE0000);
    step(); cmd_addr = 16'h0008; #1;
    chk("b2b2_rdy",   32'(cmd_ready), 32'd1);
    chk("b2b1_vld",   32'(rsp_valid), 32'd1);
    chk("b2b1_rdata", rsp_rdata,      32'hCAFE0001);
    step(); cmd_valid = 1'b0; #1;
    chk("b2b2_vld",   32'(rsp_valid), 32'd1);
    chk("b2b2_rdata", rsp_rdata,      32'hCAFE0002);
    step();
    chk("b2b_drained", 32'(rsp_valid), 32'd0);

    // Stall: fetch 0x20 then hold rsp_ready low 3 cycles with 0x24 pending
    cmd_valid = 1'b1; cmd_addr = 16'h0020; #1;
    chk("st_cs20", 32'(ram_cs), 32'd1);
    step(); rsp_ready = 1'b0; cmd_addr = 16'h0024; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_vld",   32'(rsp_valid), 32'd1);
      chk("st_rdy",   32'(cmd_ready), 32'd0);
      chk("st_cs",    32'(ram_cs),    32'd0);
      chk("st_rdata", rsp_rdata,      32'hCAFE0008);
      if (i < 2) step();
    end
    step(); rsp_ready = 1'b1; #1;
    chk("st_rel_rdy",   32'(cmd_ready), 32'd1);
    chk("st_rel_cs",    32'(ram_cs),    32'd1);
    chk("st_rel_addr",  32'(ram_addr),  32'h9);
    chk("st_rel_rdata", rsp_rdata,      32'hCAFE0008);
    step(); cmd_valid = 1'b0; #1;
    chk("st_w9_vld",   32'(rsp_valid), 32'd1);
    chk("st_w9_rdata", rsp_rdata,      32'hCAFE0009);
    step();

    // Reuse: 0x40 twice in a row
    cmd_valid = 1'b1; cmd_addr = 16'h0040; #1;
    chk("ru_cs1", 32'(ram_cs), 32'd1);
    step(); #1;
    chk("ru_cs2",    32'(ram_cs),  32'd0);
    chk("ru_rdata1", rsp_rdata,    32'hCAFE0010);
    step(); cmd_valid = 1'b0; #1;
    chk("ru_vld2",    32'(rsp_valid), 32'd1);
    chk("ru_rdata2",  rsp_rdata,      32'hCAFE0010);
    chk("ru_holdup",  32'(holdup),    32'd1);
    step();

    // Misaligned 0x42
    cmd_valid = 1'b1; cmd_addr = 16'h0042; #1;
    chk("ma_cs", 32'(ram_cs), 32'd0);
    step(); cmd_valid = 1'b0; #1;
    chk("ma_vld",    32'(rsp_valid), 32'd1);
    chk("ma_err",    32'(rsp_err),   32'd1);
    chk("ma_rdata",  rsp_rdata,      32'h0);
    chk("ma_holdup", 32'(holdup),    32'd1);
    step();
    // last_addr still word 16: 0x40 is a reuse hit
    cmd_valid = 1'b1; cmd_addr = 16'h0040; #1;
    chk("ma_last_cs", 32'(ram_cs), 32'd0);
    step(); cmd_valid = 1'b0; #1;
    chk("ma_last_err",   32'(rsp_err), 32'd0);
    chk("ma_last_rdata", rsp_rdata,    32'hCAFE0010);
    step();

    // Top word 0xFFFC
    cmd_valid = 1'b1; cmd_addr = 16'hFFFC; #1;
    chk("top_cs",   32'(ram_cs),   32'd1);
    chk("top_addr", 32'(ram_addr), 32'h3FFF);
    step(); cmd_valid = 1'b0; #1;
    chk("top_rdata", rsp_rdata, 32'hCAFE3FFF);
    step();

    // Reset mid-transaction with a stalled response
    cmd_valid = 1'b1; cmd_addr = 16'h0040; #1;
    chk("rs_cs", 32'(ram_cs), 32'd1);
    step(); cmd_valid = 1'b0; rsp_ready = 1'b0;
    step();
    chk("rs_stalled", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("rs_vld",    32'(rsp_valid), 32'd0);
    chk("rs_holdup", 32'(holdup),    32'd0);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 16'h0040; #1;
    chk("rs_post_cs", 32'(ram_cs), 32'd1);
    step(); cmd_valid = 1'b0; #1;
    chk("rs_post_vld",    32'(rsp_valid), 32'd1);
    chk("rs_post_rdata",  rsp_rdata,      32'hCAFE0010);
    chk("rs_post_holdup", 32'(holdup),    32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
